ram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the 256x8 RAM_array in the toy processor.

---
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the 256x8 RAM array.
// Optional RAM_ARB_LOCK_EN adds per-requester LOCK inputs to hold the grant.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  output logic              o_r0_ack,
  output logic [DATA_W-1:0] o_r0_rdata,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r1_ack,
  output logic [DATA_W-1:0] o_r1_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              i_r0_lock,
  input  logic              i_r1_lock,
`endif
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data_in,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_data_out,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_we_q;
  logic              r_gnt;
  logic              r_last_gnt;
  logic              r_r0_ack;
  logic              r_r1_ack;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic [DATA_W-1:0] r_r0_rdata;
  logic [DATA_W-1:0] r_r1_rdata;

  logic w_any;
  logic w_pick;

`ifdef RAM_ARB_LOCK_EN
  // Lock owner is always the last granted requester.
  logic r_lock;
`endif

  always_comb begin
    w_any  = i_r0_req | i_r1_req;
    w_pick = 1'b0;
    if (i_r0_req && i_r1_req) begin
      w_pick = ~r_last_gnt;
    end else begin
      w_pick = i_r1_req;
    end
`ifdef RAM_ARB_LOCK_EN
    if (r_lock) begin
      w_any  = r_last_gnt ? i_r1_req : i_r0_req;
      w_pick = r_last_gnt;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_we_q     <= 1'b0;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_r0_ack   <= 1'b0;
      r_r1_ack   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_r0_rdata <= '0;
      r_r1_rdata <= '0;
`ifdef RAM_ARB_LOCK_EN
      r_lock     <= 1'b0;
`endif
    end else begin
      r_r0_ack <= 1'b0;
      r_r1_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_pick;
            r_ram_addr <= w_pick ? i_r1_addr : i_r0_addr;
            r_ram_din  <= w_pick ? i_r1_wdata : i_r0_wdata;
            r_we_q     <= w_pick ? i_r1_we : i_r0_we;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we_q) begin
            if (r_gnt) begin
              r_r1_rdata <= i_ram_data_out;
            end else begin
              r_r0_rdata <= i_ram_data_out;
            end
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_r0_ack   <= ~r_gnt;
          r_r1_ack   <= r_gnt;
          r_last_gnt <= r_gnt;
`ifdef RAM_ARB_LOCK_EN
          r_lock     <= r_gnt ? i_r1_lock : i_r0_lock;
`endif
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write strobe decodes from state so an async reset drops it at once.
  assign o_ram_we      = (r_state == S_ACCESS) && r_we_q;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_data_in = r_ram_din;
  assign o_r0_ack      = r_r0_ack;
  assign o_r1_ack      = r_r1_ack;
  assign o_r0_rdata    = r_r0_rdata;
  assign o_r1_rdata    = r_r1_rdata;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256x8 RAM.
// Lock scenario runs only when RAM_ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       r0_req, r0_we, r0_ack;
  logic [7:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_we, r1_ack;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_we, busy;
`ifdef RAM_ARB_LOCK_EN
  logic       r0_lock, r1_lock;
`endif

  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_r0_req      (r0_req),
    .i_r0_we       (r0_we),
    .i_r0_addr     (r0_addr),
    .i_r0_wdata    (r0_wdata),
    .o_r0_ack      (r0_ack),
    .o_r0_rdata    (r0_rdata),
    .i_r1_req      (r1_req),
    .i_r1_we       (r1_we),
    .i_r1_addr     (r1_addr),
    .i_r1_wdata    (r1_wdata),
    .o_r1_ack      (r1_ack),
    .o_r1_rdata    (r1_rdata),
`ifdef RAM_ARB_LOCK_EN
    .i_r0_lock     (r0_lock),
    .i_r1_lock     (r1_lock),
`endif
    .o_ram_addr    (ram_addr),
    .o_ram_data_in (ram_din),
    .o_ram_we      (ram_we),
    .i_ram_data_out(ram_dout),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ram_we, r0_ack, r1_ack, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl: we/ack0/ack1/busy=%b want 0000",
               {ram_we, r0_ack, r1_ack, busy});
    end
    checks++;
    if ({ram_addr, ram_din, r0_rdata, r1_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: addr/din/rd0/rd1=%h want 00000000",
               {ram_addr, ram_din, r0_rdata, r1_rdata});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    r0_we = 1'b1; r0_addr = 8'h05; r0_wdata = 8'hAF; r0_req = 1'b1;
    step();
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'h05, 8'hAF}) begin
      errors++;
      $display("FAIL wr_access: we=%b addr=%h din=%h want 1/05/af",
               ram_we, ram_addr, ram_din);
    end
    step();
    checks++;
    if ({ram_we, r0_ack, busy} !== 3'b001) begin
      errors++;
      $display("FAIL wr_done: we/ack/busy=%b want 001", {ram_we, r0_ack, busy});
    end
    step();
    checks++;
    if ({r0_ack, r1_ack, busy} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ack: ack0/ack1/busy=%b want 100", {r0_ack, r1_ack, busy});
    end
    checks++;
    if (mem[8'h05] !== 8'hAF) begin
      errors++;
      $display("FAIL wr_mem: got %h want af", mem[8'h05]);
    end
    r0_req = 1'b0;
    step();
    checks++;
    if ({r0_ack, ram_we} !== 2'b00) begin
      errors++;
      $display("FAIL wr_pulse: ack/we=%b want 00", {r0_ack, ram_we});
    end
  endtask

  task automatic test_read();
    r1_we = 1'b0; r1_addr = 8'h05; r1_req = 1'b1;
    step();
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_we: got %b want 0", ram_we);
    end
    step();
    step();
    checks++;
    if ({r1_ack, r0_ack, r1_rdata} !== {2'b10, 8'hAF}) begin
      errors++;
      $display("FAIL rd_ack: ack1/ack0=%b rdata=%h want 10/af",
               {r1_ack, r0_ack}, r1_rdata);
    end
    checks++;
    if (r0_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_other: r0_rdata=%h want 00", r0_rdata);
    end
    r1_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int i0 = 0;
    int i1 = 0;
    r0_we = 1'b1; r0_addr = 8'h10; r0_wdata = 8'hA0; r0_req = 1'b1;
    r1_we = 1'b0; r1_addr = 8'h10; r1_req = 1'b1;
    for (int s = 1; s <= 30 && n < 8; s++) begin
      step();
      if (r0_ack || r1_ack) begin
        checks++;
        if (s !== 3 * (n + 1)) begin
          errors++;
          $display("FAIL b2b_gap: ack %0d at cycle %0d want %0d", n, s, 3 * (n + 1));
        end
        checks++;
        if ({r0_ack, r1_ack} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL b2b_order: ack %0d ack0/ack1=%b want %b", n,
                   {r0_ack, r1_ack}, (n % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (r1_ack) begin
          checks++;
          if (r1_rdata !== 8'(8'hA0 + i1)) begin
            errors++;
            $display("FAIL b2b_data: rd %0d got %h want %h", i1, r1_rdata, 8'(8'hA0 + i1));
          end
          i1++;
          r1_addr = 8'(8'h10 + i1);
          if (i1 == 4) r1_req = 1'b0;
        end
        if (r0_ack) begin
          i0++;
          r0_addr  = 8'(8'h10 + i0);
          r0_wdata = 8'(8'hA0 + i0);
          if (i0 == 4) r0_req = 1'b0;
        end
        n++;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks want 8", n);
    end
    step();
  endtask

  task automatic test_addr_edge();
    r0_we = 1'b1; r0_addr = 8'hFF; r0_wdata = 8'h5A; r0_req = 1'b1;
    step();
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL edge_addr: we=%b addr=%h want 1/ff", ram_we, ram_addr);
    end
    step();
    step();
    r0_req = 1'b0;
    step();
    r0_we = 1'b0; r0_req = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({r0_ack, r0_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL edge_read: ack=%b rdata=%h want 1/5a", r0_ack, r0_rdata);
    end
    r0_req = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int acks = 0;
    r0_we = 1'b1; r0_addr = 8'h20; r0_wdata = 8'h55; r0_req = 1'b1;
    step();
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_access: we=%b want 1", ram_we);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, r0_ack, r1_ack, busy, ram_addr} !== 12'h000) begin
      errors++;
      $display("FAIL abort_async: we/ack0/ack1/busy=%b addr=%h want 0000/00",
               {ram_we, r0_ack, r1_ack, busy}, ram_addr);
    end
    r0_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      if (r0_ack) acks++;
    end
    checks++;
    if (acks !== 0 || mem[8'h20] !== 8'h00) begin
      errors++;
      $display("FAIL abort_noack: acks=%0d mem=%h want 0/00", acks, mem[8'h20]);
    end
    r1_we = 1'b0; r1_addr = 8'h05; r1_req = 1'b1;
    step(); step(); step();
    r1_req = 1'b0;
    checks++;
    if ({r1_ack, r1_rdata} !== {1'b1, 8'hAF}) begin
      errors++;
      $display("FAIL abort_rd05: ack=%b rdata=%h want 1/af", r1_ack, r1_rdata);
    end
    step();
    r1_addr = 8'h20; r1_req = 1'b1;
    step(); step(); step();
    r1_req = 1'b0;
    checks++;
    if ({r1_ack, r1_rdata} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL abort_rd20: ack=%b rdata=%h want 1/00", r1_ack, r1_rdata);
    end
    step();
  endtask

  task automatic test_withdraw();
    int a0 = 0;
    int a1 = 0;
    r1_we = 1'b0; r1_addr = 8'h05; r1_req = 1'b1;
    step();
    r0_we = 1'b1; r0_addr = 8'h30; r0_wdata = 8'h77; r0_req = 1'b1;
    step();
    r0_req = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (r1_ack) begin
        a1++;
        r1_req = 1'b0;
      end
      if (r0_ack) a0++;
    end
    checks++;
    if (a0 !== 0 || a1 !== 1 || mem[8'h30] !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL withdraw: acks0=%0d acks1=%0d mem=%h busy=%b want 0/1/00/0",
               a0, a1, mem[8'h30], busy);
    end
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    int k = 0;
    r0_lock = 1'b1;
    r0_we = 1'b0; r0_addr = 8'h05; r0_req = 1'b1;
    r1_we = 1'b0; r1_addr = 8'h10; r1_req = 1'b1;
    for (int s = 0; s < 30 && k < 4; s++) begin
      step();
      if (r0_ack || r1_ack) begin
        checks++;
        if ({r0_ack, r1_ack} !== ((k < 3) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL lock_order: grant %0d ack0/ack1=%b want %b", k,
                   {r0_ack, r1_ack}, (k < 3) ? 2'b10 : 2'b01);
        end
        k++;
        if (k == 2) r0_lock = 1'b0;
        if (k == 3) r0_req = 1'b0;
        if (k == 4) r1_req = 1'b0;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL lock_count: got %0d grants want 4", k);
    end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
`ifdef RAM_ARB_LOCK_EN
    r0_lock = 1'b0;
    r1_lock = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_addr_edge();
    test_abort();
    test_withdraw();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
